// File: rtl/timer_counter_n_if.sv
// Control/status bundle between the prescaler/register block and timer_counter_n.
// clk_ena is a one-cycle qualifier rather than a valid/ready pair: every posedge with clk_ena=1 is one tick, no backpressure.
interface timer_counter_n_if #(
    parameter int unsigned WIDTH = 8
);
    logic             clk_ena;
    logic [WIDTH-1:0] start_counter;
    logic [WIDTH-1:0] cmp_val;
    logic             up_down;
    logic             load;
    logic             enable;
    logic [1:0]       mode;
    logic             clr_overflow;
    logic             clr_underflow;
    logic             clr_cmp;
    logic [2:0]       irq_mask;
    logic [WIDTH-1:0] cnt;
    logic             overflow;
    logic             underflow;
    logic             cmp_match;
    logic             running;
    logic             irq;

    modport master (
        output clk_ena, start_counter, cmp_val, up_down, load, enable, mode,
               clr_overflow, clr_underflow, clr_cmp, irq_mask,
        input  cnt, overflow, underflow, cmp_match, running, irq
    );

    modport slave (
        input  clk_ena, start_counter, cmp_val, up_down, load, enable, mode,
               clr_overflow, clr_underflow, clr_cmp, irq_mask,
        output cnt, overflow, underflow, cmp_match, running, irq
    );
endinterface

// File: rtl/timer_counter_n.sv
// Generic-width up/down timer counter with free-run, auto-reload and one-shot modes,
// sticky overflow/underflow/compare flags and a masked, registered interrupt.
module timer_counter_n #(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic               clk,
    input logic               rst,
    timer_counter_n_if.slave  bus
);
    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             cmp_q, cmp_d;
    logic             irq_q, irq_d;
    logic             ovf_set, unf_set, cmp_set;
    logic             terminal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= RESET_VAL;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            cmp_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            cmp_q   <= cmp_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        cmp_set  = 1'b0;
        terminal = 1'b0;

        if (bus.load) begin
            // Load wins over any tick and never raises a flag.
            cnt_d   = bus.start_counter;
            state_d = RUN;
        end else if (bus.clk_ena && bus.enable && (state_q == RUN)) begin
            if (bus.up_down) begin
                terminal = (cnt_q == MAX_VAL);
                ovf_set  = terminal;
                cnt_d    = cnt_q + 1'b1;
            end else begin
                terminal = (cnt_q == '0);
                unf_set  = terminal;
                cnt_d    = cnt_q - 1'b1;
            end

            if (terminal) begin
                case (bus.mode)
                    2'b01: cnt_d = bus.start_counter;
                    2'b10: begin
                        cnt_d   = bus.start_counter;
                        state_d = HALT;
                    end
                    default: ;
                endcase
            end

            // Compare against the value actually landed on, i.e. after any reload.
            cmp_set = (cnt_d == bus.cmp_val);
        end

        ovf_d = ovf_set | (ovf_q & ~bus.clr_overflow);
        unf_d = unf_set | (unf_q & ~bus.clr_underflow);
        cmp_d = cmp_set | (cmp_q & ~bus.clr_cmp);
        irq_d = |({cmp_q, unf_q, ovf_q} & bus.irq_mask);
    end

    assign bus.cnt       = cnt_q;
    assign bus.overflow  = ovf_q;
    assign bus.underflow = unf_q;
    assign bus.cmp_match = cmp_q;
    assign bus.running   = (state_q == RUN);
    assign bus.irq       = irq_q;
endmodule

// File: tb/tb_timer_counter_n.sv
// Bench for timer_counter_n: WIDTH=8 and WIDTH=16 instances share one stimulus stream,
// a behavioural model predicts each edge and a monitor compares after the edge.
module tb_timer_counter_n;
    localparam int EW = 21;  // {cnt[15:0], ovf, unf, cmp, running, irq}

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        s_ena, s_up, s_load, s_en, s_clr_ov, s_clr_un, s_clr_cm;
    logic [15:0] s_sc, s_cmp;
    logic [1:0]  s_mode;
    logic [2:0]  s_mask;

    timer_counter_n_if #(.WIDTH(8))  b8 ();
    timer_counter_n_if #(.WIDTH(16)) b16 ();

    timer_counter_n #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    timer_counter_n #(.WIDTH(16), .RESET_VAL(16'h0007)) dut16 (.clk(clk), .rst(rst), .bus(b16));

    assign b8.clk_ena        = s_ena;
    assign b8.start_counter  = s_sc[7:0];
    assign b8.cmp_val        = s_cmp[7:0];
    assign b8.up_down        = s_up;
    assign b8.load           = s_load;
    assign b8.enable         = s_en;
    assign b8.mode           = s_mode;
    assign b8.clr_overflow   = s_clr_ov;
    assign b8.clr_underflow  = s_clr_un;
    assign b8.clr_cmp        = s_clr_cm;
    assign b8.irq_mask       = s_mask;
    assign b16.clk_ena       = s_ena;
    assign b16.start_counter = s_sc;
    assign b16.cmp_val       = s_cmp;
    assign b16.up_down       = s_up;
    assign b16.load          = s_load;
    assign b16.enable        = s_en;
    assign b16.mode          = s_mode;
    assign b16.clr_overflow  = s_clr_ov;
    assign b16.clr_underflow = s_clr_un;
    assign b16.clr_cmp       = s_clr_cm;
    assign b16.irq_mask      = s_mask;

    // ---------------- scoreboard state ----------------
    logic [EW-1:0] exp8_q[$];
    logic [EW-1:0] exp16_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = WIDTH 8, index 1 = WIDTH 16
    int unsigned m_cnt [2];
    logic        m_ov  [2];
    logic        m_un  [2];
    logic        m_cm  [2];
    logic        m_run [2];
    logic        m_irq [2];

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k, input int w, input int unsigned rv);
        int unsigned mx, sc, cv, nc;
        logic        ovs, uns, cms, nrun, nirq, term;
        mx   = (32'd1 << w) - 1;
        sc   = 32'(s_sc) & mx;
        cv   = 32'(s_cmp) & mx;
        nc   = m_cnt[k];
        nrun = m_run[k];
        ovs  = 1'b0;
        uns  = 1'b0;
        cms  = 1'b0;
        term = 1'b0;
        nirq = (m_ov[k] & s_mask[0]) | (m_un[k] & s_mask[1]) | (m_cm[k] & s_mask[2]);
        if (rst) begin
            m_cnt[k] = rv;
            m_ov[k]  = 1'b0;
            m_un[k]  = 1'b0;
            m_cm[k]  = 1'b0;
            m_run[k] = 1'b1;
            m_irq[k] = 1'b0;
        end else begin
            if (s_load) begin
                nc   = sc;
                nrun = 1'b1;
            end else if (s_ena && s_en && m_run[k]) begin
                if (s_up) begin
                    if (m_cnt[k] == mx) begin term = 1'b1; ovs = 1'b1; nc = 0; end
                    else nc = m_cnt[k] + 1;
                end else begin
                    if (m_cnt[k] == 0) begin term = 1'b1; uns = 1'b1; nc = mx; end
                    else nc = m_cnt[k] - 1;
                end
                if (term && s_mode == 2'b01) nc = sc;
                if (term && s_mode == 2'b10) begin nc = sc; nrun = 1'b0; end
                cms = (nc == cv);
            end
            m_cnt[k] = nc;
            m_run[k] = nrun;
            m_ov[k]  = ovs | (m_ov[k] & ~s_clr_ov);
            m_un[k]  = uns | (m_un[k] & ~s_clr_un);
            m_cm[k]  = cms | (m_cm[k] & ~s_clr_cm);
            m_irq[k] = nirq;
        end
    endtask

    // One clock: predict the coming edge, let it happen, return at the next negedge.
    task automatic tick();
        model_step(0, 8, 32'h0);
        model_step(1, 16, 32'h7);
        exp8_q.push_back({16'(m_cnt[0]), m_ov[0], m_un[0], m_cm[0], m_run[0], m_irq[0]});
        exp16_q.push_back({16'(m_cnt[1]), m_ov[1], m_un[1], m_cm[1], m_run[1], m_irq[1]});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0; s_ena = 1'b0; s_load = 1'b0;
        s_clr_ov = 1'b0; s_clr_un = 1'b0; s_clr_cm = 1'b0;
    endtask

    task automatic clear_flags();
        s_clr_ov = 1'b1; s_clr_un = 1'b1; s_clr_cm = 1'b1;
        tick();
        s_clr_ov = 1'b0; s_clr_un = 1'b0; s_clr_cm = 1'b0;
    endtask

    task automatic load_val(input logic [15:0] v);
        s_sc = v; s_load = 1'b1;
        tick();
        s_load = 1'b0;
    endtask

    task automatic pulse_tick();
        s_ena = 1'b1;
        tick();
        s_ena = 1'b0;
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        logic [EW-1:0] e;
        #1;
        if (exp8_q.size() > 0) begin
            e = exp8_q.pop_front();
            chk("cnt8", 32'(b8.cnt), 32'(e[20:5]));
            chk("ovf8", 32'(b8.overflow), 32'(e[4]));
            chk("unf8", 32'(b8.underflow), 32'(e[3]));
            chk("cmp8", 32'(b8.cmp_match), 32'(e[2]));
            chk("run8", 32'(b8.running), 32'(e[1]));
            chk("irq8", 32'(b8.irq), 32'(e[0]));
        end
        if (exp16_q.size() > 0) begin
            e = exp16_q.pop_front();
            chk("cnt16", 32'(b16.cnt), 32'(e[20:5]));
            chk("ovf16", 32'(b16.overflow), 32'(e[4]));
            chk("unf16", 32'(b16.underflow), 32'(e[3]));
            chk("cmp16", 32'(b16.cmp_match), 32'(e[2]));
            chk("run16", 32'(b16.running), 32'(e[1]));
            chk("irq16", 32'(b16.irq), 32'(e[0]));
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; s_ena = 1'b0; s_up = 1'b0; s_load = 1'b0; s_en = 1'b1;
        s_clr_ov = 1'b0; s_clr_un = 1'b0; s_clr_cm = 1'b0;
        s_sc = 16'h0; s_cmp = 16'hFFFF; s_mode = 2'b00; s_mask = 3'b000;
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_ov[k] = 0; m_un[k] = 0; m_cm[k] = 0; m_run[k] = 1; m_irq[k] = 0;
        end
        @(negedge clk);
        tick();
        tick();
        chk("reset_cnt8", 32'(b8.cnt), 32'h0);
        chk("reset_cnt16", 32'(b16.cnt), 32'h7);
        chk("reset_run", 32'(b8.running), 32'h1);
        idle_inputs();

        // Free-run down from 10: underflow on the 11th tick
        s_mode = 2'b00; s_up = 1'b0;
        load_val(16'd10);
        for (int i = 1; i <= 11; i++) begin
            pulse_tick();
            tick();
            if (i == 10) chk("fr_no_flag", 32'(b8.underflow), 32'h0);
        end
        chk("fr_wrap_cnt", 32'(b8.cnt), 32'd255);
        chk("fr_unf", 32'(b8.underflow), 32'h1);
        chk("fr_ovf", 32'(b8.overflow), 32'h0);
        clear_flags();

        // Auto-reload up from 250: overflow on 6th tick, masked irq one cycle later
        s_mode = 2'b01; s_up = 1'b1; s_mask = 3'b001;
        load_val(16'd250);
        for (int i = 0; i < 6; i++) pulse_tick();
        chk("ar_cnt", 32'(b8.cnt), 32'd250);
        chk("ar_ovf", 32'(b8.overflow), 32'h1);
        chk("ar_irq_lag", 32'(b8.irq), 32'h0);
        tick();
        chk("ar_irq", 32'(b8.irq), 32'h1);
        s_clr_ov = 1'b1;
        tick();
        s_clr_ov = 1'b0;
        chk("ar_ovf_clr", 32'(b8.overflow), 32'h0);
        tick();
        chk("ar_irq_clr", 32'(b8.irq), 32'h0);
        clear_flags();

        // One-shot down from 3: halt after 4th tick, reload resumes counting
        s_mode = 2'b10; s_up = 1'b0;
        load_val(16'd3);
        for (int i = 0; i < 4; i++) pulse_tick();
        chk("os_cnt", 32'(b8.cnt), 32'd3);
        chk("os_unf", 32'(b8.underflow), 32'h1);
        chk("os_halt", 32'(b8.running), 32'h0);
        s_mode = 2'b00;
        for (int i = 0; i < 5; i++) pulse_tick();
        chk("os_held", 32'(b8.cnt), 32'd3);
        s_mode = 2'b10;
        load_val(16'd3);
        chk("os_rerun", 32'(b8.running), 32'h1);
        pulse_tick();
        chk("os_resume", 32'(b8.cnt), 32'd2);
        clear_flags();

        // Compare match at 0x00F4; a clear coinciding with a set leaves it set
        s_mode = 2'b01; s_up = 1'b1; s_cmp = 16'h00F4; s_mask = 3'b100;
        load_val(16'h00F0);
        for (int i = 0; i < 3; i++) pulse_tick();
        chk("cm_early", 32'(b16.cmp_match), 32'h0);
        pulse_tick();
        chk("cm_hit", 32'(b16.cmp_match), 32'h1);
        load_val(16'h00F3);
        s_clr_cm = 1'b1;
        pulse_tick();
        s_clr_cm = 1'b0;
        chk("cm_set_wins", 32'(b16.cmp_match), 32'h1);
        s_clr_cm = 1'b1;
        tick();
        s_clr_cm = 1'b0;
        chk("cm_cleared", 32'(b16.cmp_match), 32'h0);
        clear_flags();

        // Load on a tick cycle, then reset mid-count
        s_mode = 2'b00; s_up = 1'b1; s_cmp = 16'h0005;
        s_sc = 16'd5; s_load = 1'b1; s_ena = 1'b1;
        tick();
        s_load = 1'b0; s_ena = 1'b0;
        chk("ld_cnt", 32'(b8.cnt), 32'd5);
        chk("ld_no_cmp", 32'(b8.cmp_match), 32'h0);
        s_sc = 16'hFFFF; load_val(16'hFFFF);
        pulse_tick();
        pulse_tick();
        rst = 1'b1; s_ena = 1'b1; s_load = 1'b1;
        tick();
        idle_inputs();
        chk("rst_cnt8", 32'(b8.cnt), 32'h0);
        chk("rst_cnt16", 32'(b16.cnt), 32'h7);
        chk("rst_flags", 32'({b8.overflow, b8.underflow, b8.cmp_match}), 32'h0);
        chk("rst_run", 32'(b8.running), 32'h1);

        // Randomized run against the model
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 299) == 0);
            s_load   = ($urandom_range(0, 19) == 0);
            s_ena    = ($urandom_range(0, 1) == 1);
            s_en     = ($urandom_range(0, 7) != 0);
            s_up     = ($urandom_range(0, 15) != 0) ? s_up : ~s_up;
            s_mode   = 2'($urandom_range(0, 3));
            s_mask   = 3'($urandom_range(0, 7));
            s_clr_ov = ($urandom_range(0, 9) == 0);
            s_clr_un = ($urandom_range(0, 9) == 0);
            s_clr_cm = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0)
                s_sc = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 12))
                                                   : 16'(16'hFFFF - $urandom_range(0, 12));
            if ($urandom_range(0, 7) == 0)
                s_cmp = s_sc + 16'($urandom_range(0, 6)) - 16'd3;
            tick();
        end
        idle_inputs();
        tick();
        tick();

        chk("queue8_drained", exp8_q.size(), 0);
        chk("queue16_drained", exp16_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
